rotating_xbar_pipe: RTL and testbench
=====================================

Name: rotating_xbar_pipe

Overview:
- Registered, flow-controlled successor to the combinational rotating crossbar.
- Rotates an N-lane vector by a select amount: out[j] = in[(sel+j) mod N].
- Sits between producer and consumer stages with valid/ready on both sides.
- Adds an auto-rotate mode: an internal round-robin pointer supplies the select and advances on each accepted transfer.

Parameters:
- NUM_DATA, 4, number of lanes; must be >= 2; need not be a power of 2.
- DATA_WIDTH, 4, bits per lane.
- AUTO_STEP, 1, pointer increment per accepted auto-mode transfer; taken mod NUM_DATA.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- input_vector_i  in  NUM_DATA*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- input_valid_i  in  1  producer has a vector.
- input_ready_o  out  1  block can accept.
- start_select_i  in  $clog2(NUM_DATA)  rotation amount in manual mode.
- auto_rotate_i  in  1  1 = use internal pointer, 0 = use start_select_i.
- output_vector_o  out  NUM_DATA*DATA_WIDTH  rotated vector, registered.
- output_valid_o  out  1  output register holds data.
- output_ready_i  in  1  consumer accepts.
- output_select_o  out  $clog2(NUM_DATA)  effective select used for the held output.

Behaviour:
- Reset is synchronous and active-high on rst_i, clock clk_i.
- On reset:
  - output_valid_o=0, output_vector_o=0, output_select_o=0.
  - Pointer=0.
  - input_ready_o=1 from the first cycle after reset deasserts.
- While rst_i=1, input_ready_o=0 and no transfer occurs.
- Reset mid-operation discards any held output; no data appears afterwards.
- Single output register stage:
  - input_ready_o = !output_valid_o || output_ready_i (combinational pass-through of ready).
  - Accept occurs when input_valid_i && input_ready_o.
  - Latency: one cycle from accept to output_valid_o=1.
- On accept:
  - eff_sel = auto_rotate_i ? ptr : (start_select_i mod NUM_DATA).
  - output_vector_o lane j <= input lane (eff_sel+j) mod NUM_DATA.
  - output_select_o <= eff_sel.
  - output_valid_o <= 1.
- Output held, no accept:
  - If output_ready_i=1, output_valid_o <= 0.
  - If output_ready_i=0, all outputs are held stable.
- Simultaneous drain and accept (output_valid_o=1, output_ready_i=1, input_valid_i=1): the new data replaces the old, valid stays 1, no bubble.
- Pointer:
  - Advances ptr <= (ptr+AUTO_STEP) mod NUM_DATA only on an accept with auto_rotate_i=1.
  - Unchanged in manual mode or when no accept occurs.
  - Wrap example: NUM_DATA=3, AUTO_STEP=2 gives the sequence 0,2,1,0.
- Manual selects >= NUM_DATA (non-power-of-2 NUM_DATA only) are reduced mod NUM_DATA.
- No state machine beyond the valid flag and pointer.
- All mod arithmetic is computed at $clog2(NUM_DATA)+1 bits to avoid overflow.

Optional Feature:
- Macro: ROTATING_XBAR_PIPE_REVERSE_EN.
- Defined:
  - Adds port reverse_i (in, 1), sampled on accept.
  - reverse_i=1 gives out[j] = in[(eff_sel-j) mod NUM_DATA].
  - reverse_i=0 gives the forward mapping.
  - Implemented as an input-lane mirror in'[k]=in[(-k) mod N] feeding the rotator with select (-eff_sel) mod N.
  - output_select_o still reports eff_sel.
- Not defined: port absent; forward rotation only.

Decomposition:
- Package rotating_xbar_pkg holds:
  - the lane-index width function (idx width = $clog2(NUM_DATA));
  - a mod-N add/sub helper function.
- Data and select types stay parameter-dependent local typedefs in the module.
- One sub-module: the existing combinational rotating_xbar, instanced once as the rotation datapath.
- rotating_xbar_pipe adds only the handshake register, the pointer, and the optional mirror.

Test Plan:
- Manual forward rotation:
  - Stimulus: N=4, W=4, lanes {3:D,2:C,1:B,0:A}, sel=1, valid=1, out_ready=1.
  - Response: next cycle output_valid_o=1, lanes {3:A,2:D,1:C,0:B}, output_select_o=1.
- Auto-rotate:
  - Stimulus: 5 back-to-back accepts, auto_rotate_i=1, AUTO_STEP=1, constant input as above.
  - Response: output_select_o sequence 0,1,2,3,0; lane0 outputs A,B,C,D,A.
- Backpressure:
  - Stimulus: hold output_ready_i=0 for 3 cycles after one accept.
  - Response: input_ready_o=0, outputs stable.
  - Stimulus: release with new input valid.
  - Response: same-cycle replacement, no bubble, no lost or duplicated vector (scoreboard count = sent count).
- Reset mid-transfer:
  - Stimulus: assert rst_i while output_valid_o=1 and ptr=2.
  - Response: next cycle output_valid_o=0, vector=0; the first auto accept after reset uses select 0.
- Non-power-of-2 wrap:
  - Stimulus: N=3, AUTO_STEP=2, auto mode.
  - Response: selects 0,2,1,0.
  - Stimulus: manual start_select_i=3.
  - Response: treated as 0.
- Reverse (macro defined):
  - Stimulus: N=4, lanes {D,C,B,A}, sel=1, reverse_i=1.
  - Response: lanes {3:C,2:D,1:A,0:B}.
- Random soak: 10k random transfers, all selects, random ready; zero mismatches against the reference model.

Source files
------------

// File: rtl/rotating_xbar_pkg.sv
// Shared helpers for the rotating crossbar family: lane-index width and
// small-range modular add/sub used for select and pointer arithmetic.
package rotating_xbar_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operands are assumed below n (or below 2n for a plain reduction with b=0),
    // so a single conditional correction replaces a divider.
    function automatic int unsigned mod_addsub(
        input int unsigned a,
        input int unsigned b,
        input int unsigned n,
        input logic        sub
    );
        int unsigned s;
        if (sub) begin
            s = (a >= b) ? (a - b) : (a + n - b);
        end else begin
            s = a + b;
            if (s >= n) begin
                s = s - n;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/rotating_xbar.sv
// Combinational lane rotator: lane j of the output takes input lane
// (select + j) mod NUM_DATA. The select must already be below NUM_DATA.
module rotating_xbar
    import rotating_xbar_pkg::*;
#(
    parameter int NUM_DATA   = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic [NUM_DATA*DATA_WIDTH-1:0]   input_vector_i,
    input  logic [idx_width(NUM_DATA)-1:0]   start_select_i,
    output logic [NUM_DATA*DATA_WIDTH-1:0]   output_vector_o
);

    localparam int IDX_W = idx_width(NUM_DATA);
    localparam int MW    = IDX_W + 1;

    typedef logic [DATA_WIDTH-1:0] lane_t;
    typedef logic [MW-1:0]         modw_t;

    lane_t in_lanes [NUM_DATA];
    modw_t src;

    always_comb begin
        src             = '0;
        output_vector_o = '0;
        for (int k = 0; k < NUM_DATA; k++) begin
            in_lanes[k] = input_vector_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int j = 0; j < NUM_DATA; j++) begin
            src = modw_t'(mod_addsub(32'(start_select_i), j, NUM_DATA, 1'b0));
            output_vector_o[j*DATA_WIDTH +: DATA_WIDTH] = in_lanes[src[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/rotating_xbar_pipe.sv
// Registered valid/ready wrapper around rotating_xbar with an auto-rotate pointer.
// Optional ROTATING_XBAR_PIPE_REVERSE_EN adds reverse_i for mirrored rotation.
module rotating_xbar_pipe
    import rotating_xbar_pkg::*;
#(
    parameter int NUM_DATA   = 4,
    parameter int DATA_WIDTH = 4,
    parameter int AUTO_STEP  = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_DATA*DATA_WIDTH-1:0]  input_vector_i,
    input  logic                            input_valid_i,
    output logic                            input_ready_o,
    input  logic [idx_width(NUM_DATA)-1:0]  start_select_i,
    input  logic                            auto_rotate_i,
`ifdef ROTATING_XBAR_PIPE_REVERSE_EN
    input  logic                            reverse_i,
`endif
    output logic [NUM_DATA*DATA_WIDTH-1:0]  output_vector_o,
    output logic                            output_valid_o,
    input  logic                            output_ready_i,
    output logic [idx_width(NUM_DATA)-1:0]  output_select_o
);

    localparam int          IDX_W    = idx_width(NUM_DATA);
    localparam int          MW       = IDX_W + 1;
    localparam int unsigned STEP_MOD = AUTO_STEP % NUM_DATA;

    typedef logic [NUM_DATA*DATA_WIDTH-1:0] vec_t;
    typedef logic [IDX_W-1:0]               sel_t;
    typedef logic [MW-1:0]                  modw_t;

    logic  vld_p1;
    logic  accept_p0;
    sel_t  ptr_q;
    sel_t  eff_sel_p0;
    sel_t  rot_sel_p0;
    sel_t  sel_p1;
    vec_t  xbar_in_p0;
    vec_t  rot_p0;
    vec_t  vec_p1;
    modw_t man_sel_w;
    modw_t ptr_next_w;

    // Stage p0: handshake, select resolution and rotation
    assign input_ready_o = !rst_i && (!vld_p1 || output_ready_i);
    assign accept_p0     = input_valid_i && input_ready_o;

    assign man_sel_w  = modw_t'(mod_addsub(32'(start_select_i), 0, NUM_DATA, 1'b0));
    assign ptr_next_w = modw_t'(mod_addsub(32'(ptr_q), STEP_MOD, NUM_DATA, 1'b0));
    assign eff_sel_p0 = auto_rotate_i ? ptr_q : sel_t'(man_sel_w);

`ifdef ROTATING_XBAR_PIPE_REVERSE_EN
    // Mirroring lanes k -> (-k) and negating the select turns the forward
    // rotator into out[j] = in[(eff_sel - j) mod N].
    vec_t  mirror_p0;
    modw_t neg_sel_w;

    for (genvar k = 0; k < NUM_DATA; k++) begin : g_mirror
        localparam int SRC = (k == 0) ? 0 : (NUM_DATA - k);
        assign mirror_p0[k*DATA_WIDTH +: DATA_WIDTH] =
            input_vector_i[SRC*DATA_WIDTH +: DATA_WIDTH];
    end

    assign neg_sel_w  = modw_t'(mod_addsub(0, 32'(eff_sel_p0), NUM_DATA, 1'b1));
    assign xbar_in_p0 = reverse_i ? mirror_p0 : input_vector_i;
    assign rot_sel_p0 = reverse_i ? sel_t'(neg_sel_w) : eff_sel_p0;
`else
    assign xbar_in_p0 = input_vector_i;
    assign rot_sel_p0 = eff_sel_p0;
`endif

    rotating_xbar #(
        .NUM_DATA   (NUM_DATA),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_xbar (
        .input_vector_i  (xbar_in_p0),
        .start_select_i  (rot_sel_p0),
        .output_vector_o (rot_p0)
    );

    // Stage p1: output register and auto-rotate pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            vec_p1 <= '0;
            sel_p1 <= '0;
            ptr_q  <= '0;
        end else if (accept_p0) begin
            vld_p1 <= 1'b1;
            vec_p1 <= rot_p0;
            sel_p1 <= eff_sel_p0;
            if (auto_rotate_i) begin
                ptr_q <= sel_t'(ptr_next_w);
            end
        end else if (output_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign output_valid_o  = vld_p1;
    assign output_vector_o = vec_p1;
    assign output_select_o = sel_p1;

endmodule

// File: tb/tb_rotating_xbar_pipe.sv
// Directed and random-soak bench for rotating_xbar_pipe (N=4 and N=3/AUTO_STEP=2 instances).
module tb_rotating_xbar_pipe;

    logic        clk;
    logic        rst;

    logic [15:0] iv4;
    logic        ivld4, irdy4, auto4, ovld4, ordy4, rev4;
    logic [1:0]  sel4, osel4;
    logic [15:0] ov4;

    logic [11:0] iv3;
    logic        ivld3, irdy3, auto3, ovld3, ordy3, rev3;
    logic [1:0]  sel3, osel3;
    logic [11:0] ov3;

    int n_chk  = 0;
    int n_fail = 0;
    int sent   = 0;
    int recv   = 0;

    rotating_xbar_pipe #(.NUM_DATA(4), .DATA_WIDTH(4), .AUTO_STEP(1)) dut4 (
        .clk_i           (clk),
        .rst_i           (rst),
        .input_vector_i  (iv4),
        .input_valid_i   (ivld4),
        .input_ready_o   (irdy4),
        .start_select_i  (sel4),
        .auto_rotate_i   (auto4),
`ifdef ROTATING_XBAR_PIPE_REVERSE_EN
        .reverse_i       (rev4),
`endif
        .output_vector_o (ov4),
        .output_valid_o  (ovld4),
        .output_ready_i  (ordy4),
        .output_select_o (osel4)
    );

    rotating_xbar_pipe #(.NUM_DATA(3), .DATA_WIDTH(4), .AUTO_STEP(2)) dut3 (
        .clk_i           (clk),
        .rst_i           (rst),
        .input_vector_i  (iv3),
        .input_valid_i   (ivld3),
        .input_ready_o   (irdy3),
        .start_select_i  (sel3),
        .auto_rotate_i   (auto3),
`ifdef ROTATING_XBAR_PIPE_REVERSE_EN
        .reverse_i       (rev3),
`endif
        .output_vector_o (ov3),
        .output_valid_o  (ovld3),
        .output_ready_i  (ordy3),
        .output_select_o (osel3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ivld4 && irdy4) sent++;
        if (!rst && ovld4 && ordy4) recv++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_rot4(input logic [15:0] v, input int s, input logic r);
        logic [15:0] o;
        int src;
        o = '0;
        for (int j = 0; j < 4; j++) begin
            src = r ? ((s - j + 4) % 4) : ((s + j) % 4);
            o[j*4 +: 4] = v[src*4 +: 4];
        end
        return o;
    endfunction

    logic [15:0] mvec;
    logic        mvld, exp_rdy;
    int          msel, mptr, esel, sent0, recv0;

    initial begin
        rst = 1'b1;
        iv4 = '0; ivld4 = 0; auto4 = 0; ordy4 = 1; sel4 = '0; rev4 = 0;
        iv3 = '0; ivld3 = 0; auto3 = 0; ordy3 = 1; sel3 = '0; rev3 = 0;
        tick;
        tick;
        chk("rdy_in_reset", 32'(irdy4), 32'd0);
        rst = 1'b0;
        tick;
        chk("rst_rdy", 32'(irdy4), 32'd1);
        chk("rst_vld", 32'(ovld4), 32'd0);
        chk("rst_vec", 32'(ov4), 32'd0);
        chk("rst_sel", 32'(osel4), 32'd0);

        // Manual forward rotation by one
        iv4 = 16'h4321; sel4 = 2'd1; ivld4 = 1; auto4 = 0; ordy4 = 1;
        tick;
        ivld4 = 0;
        chk("man_vld", 32'(ovld4), 32'd1);
        chk("man_vec", 32'(ov4), 32'h1432);
        chk("man_sel", 32'(osel4), 32'd1);
        tick;
        chk("man_drain_vld", 32'(ovld4), 32'd0);

        // Auto-rotate: five back-to-back accepts
        auto4 = 1; ivld4 = 1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("auto_sel", 32'(osel4), 32'(i % 4));
            chk("auto_lane0", 32'(ov4[3:0]), 32'((i % 4) + 1));
            chk("auto_vld", 32'(ovld4), 32'd1);
        end
        ivld4 = 0;
        tick;

        // Backpressure then same-cycle replacement
        sent0 = sent; recv0 = recv;
        ordy4 = 0; ivld4 = 1; auto4 = 0; sel4 = 2'd2; iv4 = 16'h4321;
        tick;
        iv4 = 16'h8765; sel4 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rdy", 32'(irdy4), 32'd0);
            chk("bp_vld", 32'(ovld4), 32'd1);
            chk("bp_vec", 32'(ov4), 32'h2143);
            chk("bp_sel", 32'(osel4), 32'd2);
            tick;
        end
        ordy4 = 1;
        #1;
        chk("bp_release_rdy", 32'(irdy4), 32'd1);
        tick;
        chk("repl_vld", 32'(ovld4), 32'd1);
        chk("repl_vec", 32'(ov4), 32'h7658);
        chk("repl_sel", 32'(osel4), 32'd3);
        ivld4 = 0;
        tick;
        tick;
        chk("sb_sent", 32'(sent - sent0), 32'd2);
        chk("sb_recv", 32'(recv - recv0), 32'(sent - sent0));

        // Pointer is 1 here (manual accepts leave it alone); one auto accept takes it to 2
        ordy4 = 0; ivld4 = 1; auto4 = 1; iv4 = 16'h4321;
        tick;
        ivld4 = 0;
        chk("pre_rst_sel", 32'(osel4), 32'd1);
        chk("pre_rst_vld", 32'(ovld4), 32'd1);
        rst = 1;
        tick;
        chk("midrst_vld", 32'(ovld4), 32'd0);
        chk("midrst_vec", 32'(ov4), 32'd0);
        chk("midrst_sel", 32'(osel4), 32'd0);
        chk("midrst_rdy", 32'(irdy4), 32'd0);
        rst = 0;
        tick;
        chk("postrst_vld", 32'(ovld4), 32'd0);
        chk("postrst_rdy", 32'(irdy4), 32'd1);
        ordy4 = 1; ivld4 = 1; auto4 = 1;
        tick;
        ivld4 = 0;
        chk("postrst_auto_sel", 32'(osel4), 32'd0);
        chk("postrst_auto_vec", 32'(ov4), 32'h4321);
        tick;

        // Non-power-of-2 instance: N=3, AUTO_STEP=2
        iv3 = 12'h321; auto3 = 1; ivld3 = 1; ordy3 = 1;
        tick; chk("n3_sel0", 32'(osel3), 32'd0); chk("n3_lane0_0", 32'(ov3[3:0]), 32'd1);
        tick; chk("n3_sel1", 32'(osel3), 32'd2); chk("n3_lane0_1", 32'(ov3[3:0]), 32'd3);
        tick; chk("n3_sel2", 32'(osel3), 32'd1); chk("n3_lane0_2", 32'(ov3[3:0]), 32'd2);
        tick; chk("n3_sel3", 32'(osel3), 32'd0); chk("n3_lane0_3", 32'(ov3[3:0]), 32'd1);
        auto3 = 0; sel3 = 2'd3;
        tick;
        chk("n3_man3_sel", 32'(osel3), 32'd0);
        chk("n3_man3_vec", 32'(ov3), 32'h321);
        sel3 = 2'd2;
        tick;
        chk("n3_man2_sel", 32'(osel3), 32'd2);
        chk("n3_man2_vec", 32'(ov3), 32'h213);
        ivld3 = 0;
        tick;

`ifdef ROTATING_XBAR_PIPE_REVERSE_EN
        rev4 = 1; auto4 = 0; sel4 = 2'd1; iv4 = 16'h4321; ivld4 = 1; ordy4 = 1;
        tick;
        chk("rev1_vec", 32'(ov4), 32'h3412);
        chk("rev1_sel", 32'(osel4), 32'd1);
        sel4 = 2'd0;
        tick;
        chk("rev0_vec", 32'(ov4), 32'h2341);
        ivld4 = 0; rev4 = 0;
        tick;
`endif

        // Random soak against a behavioural model
        rst = 1;
        tick;
        rst = 0;
        mvld = 0; mvec = '0; msel = 0; mptr = 0;
        for (int c = 0; c < 10000; c++) begin
            iv4   = 16'($urandom);
            sel4  = 2'($urandom);
            auto4 = 1'($urandom);
            ivld4 = 1'($urandom);
            ordy4 = ($urandom_range(3) != 0);
`ifdef ROTATING_XBAR_PIPE_REVERSE_EN
            rev4  = 1'($urandom);
`endif
            #1;
            exp_rdy = !mvld || ordy4;
            chk("soak_rdy", 32'(irdy4), 32'(exp_rdy));
            if (ivld4 && exp_rdy) begin
                esel = auto4 ? mptr : int'(sel4);
                mvec = ref_rot4(iv4, esel, rev4);
                msel = esel;
                mvld = 1;
                if (auto4) mptr = (mptr + 1) % 4;
            end else if (ordy4) begin
                mvld = 0;
            end
            tick;
            chk("soak_vld", 32'(ovld4), 32'(mvld));
            chk("soak_vec", 32'(ov4), 32'(mvec));
            chk("soak_sel", 32'(osel4), 32'(msel));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
